// File: rtl/pipe_pkg.sv
// Shared pipeline types: skid-stage state encoding and the MEM->WB payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
  } mem_wb_payload_t;

  localparam int MEM_WB_W = $bits(mem_wb_payload_t);

  // Occupancy count that corresponds to a state.
  function automatic logic [1:0] occ_of(skid_state_e st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: valid/ready handshake, two-entry skid buffer,
// synchronous flush. Every output comes straight from a flop.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 136,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q, out_valid_q;
  logic [1:0]        occ_q;

  logic accept, fire;
  logic load_main_in, load_main_skid, load_skid_in;

  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid_q & out_ready;

  // Next state and data-path steering. Flush overrides everything and
  // suppresses all data writes, so held contents survive but lose validity.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = ST_FULL;
            load_skid_in = 1'b1;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Flags are registered from the next state so no input reaches an output
  // combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload registers are reset because RESET_VAL is a defined, observable out_data value after reset.
    if (!rst_n) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occ_o     = occ_q;

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, elastic pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It is the successor to the fixed MEM→WB register: one instance sits between each pair of CPU stages, carrying the stage payload as a packed vector. The MEM→WB payload is 136 bits (PC+4, read data, ALU result, rd, RegWrite, ResultSrc, instruction). The block sustains one transfer per cycle with back-pressure, and all outputs are registered.

## Interface
- DATA_W, 136, payload width in bits (≥1)
- RESET_VAL, '0, value of the data registers after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  stage accepts this cycle (registered)
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream consumes this cycle
- out_data  out  DATA_W  head payload (registered)
- occ_o  out  2  entries held: 0, 1 or 2

## Operation
- Storage: `main` register drives out_data directly; `skid` register holds an overflow entry.
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- States:
  - EMPTY: nothing held.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions (no flush):
  - EMPTY: accept → ONE, with main ← in_data.
  - ONE, accept & fire → ONE, with main ← in_data.
  - ONE, accept & !fire → FULL, with skid ← in_data.
  - ONE, !accept & fire → EMPTY.
  - ONE, neither → ONE (hold).
  - FULL: fire → ONE, with main ← skid. No accept is possible in FULL.
- Flags:
  - in_ready = next-state ≠ FULL, registered.
  - out_valid = state ≠ EMPTY.
  - occ_o = 0, 1 or 2 for EMPTY, ONE or FULL.
- Ordering: strict FIFO order. No payload is duplicated or dropped except on flush.
- Flush:
  - Highest priority. Next state is EMPTY and in_ready becomes 1.
  - An in_data accepted in the same cycle is discarded.
  - Data registers keep their contents; only validity is cleared.
- out_data is stable while out_valid & !out_ready (hold on stall).
- Upstream protocol, assumed by the block: in_data is stable while in_valid & !in_ready. The bench checks this with an assertion.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state EMPTY
  - out_valid 0
  - in_ready 1
  - occ_o 0
  - main and skid equal RESET_VAL
- Latency: an accept into EMPTY (or ONE with a simultaneous fire) gives out_valid and out_data on the next edge.
- Throughput: 1 transfer per cycle indefinitely while out_ready = 1.
- Back-pressure:
  - in_ready drops one cycle after out_ready drops.
  - The single in-flight word lands in skid.
- No combinational path exists from out_ready to in_ready, or from in_* to out_*.
- Reset asserted mid-transfer: entries are lost immediately and out_valid falls asynchronously.
- flush_i together with a fire: the fire counts downstream. The state is still EMPTY next cycle.

## Structure
- Shared package pipe_pkg:
  - `skid_state_e` enum {ST_EMPTY, ST_ONE, ST_FULL}, 2 bits.
  - `mem_wb_payload_t` packed struct with fields pc_plus4, read_data, alu_result, instr (32 bits each), rd (5 bits), reg_write (1 bit) and result_src (2 bits).
  - Localparam `MEM_WB_W = $bits(mem_wb_payload_t)`.
- The block is flat. State register, flags and the two data registers live in one module, so no sub-module is needed.
- The CPU top instantiates pipe_skid_stage #(.DATA_W(pipe_pkg::MEM_WB_W)) for the MEM→WB link.

## Test plan
- **Reset:** hold rst_n = 0 with in_valid = 1 and in_data = 0xA5… → out_valid 0, in_ready 1, occ_o 0, out_data 0. After release, the first accepted word 0x1 appears one cycle later.
- **Streaming:** out_ready = 1, push 0x1…0x10 back-to-back → outputs 0x1…0x10 in order on consecutive cycles, occ_o constantly 1.
- **Stall:** push 0x11, 0x22, 0x33 with out_ready = 0 from cycle 1 → 0x11 held on out_data, 0x22 in skid, occ_o 2, in_ready 0, 0x33 held upstream. After out_ready = 1 the output order is 0x11, 0x22, 0x33.
- **Flush in FULL:** FULL with 0x44 and 0x55, then flush_i = 1 and in_valid = 1 with 0x66 → next cycle out_valid 0, occ_o 0, in_ready 1, and 0x66 never emerges.
- **Random stress:** random in_valid and out_ready (50%) over 10k words with random payload → scoreboard matches exactly and the in_data stability assertion never fires.
- **Asynchronous reset mid-stream:** rst_n pulses low between clock edges while FULL → out_valid falls before the next edge and occ_o is 0.
